// File: rtl/ppu_pkg.sv
// Shared PPU sprite-evaluation types, dot/line constants and the Y range test.
package ppu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        EVAL_Y,
        COPY,
        OVF_SCAN,
        DONE
    } eval_state_t;

    localparam logic [8:0] CLEAR_FIRST    = 9'd1;
    localparam logic [8:0] EVAL_FIRST     = 9'd65;
    localparam logic [8:0] EVAL_LAST      = 9'd256;
    localparam logic [8:0] PRERENDER_LINE = 9'd261;
    localparam logic [8:0] LAST_VISIBLE   = 9'd239;

    // Sprite covers the line when (scanline - Y) mod 512 is below the sprite height.
    function automatic logic spr_in_range(input logic [8:0] scanline,
                                          input logic [7:0] y,
                                          input logic       h16);
        logic [8:0] d;
        d = scanline - {1'b0, y};
        return d < (h16 ? 9'd16 : 9'd8);
    endfunction

endpackage

// File: rtl/sprite_eval.sv
// Per-scanline sprite evaluation: clears oam2, scans primary OAM, copies up to
// eight in-range sprites, and flags overflow with the NES m-increment quirk.
module sprite_eval #(
    parameter int unsigned N_SLOTS   = 8,
    parameter int unsigned N_SPRITES = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [8:0]         cycle,
    input  logic [8:0]         scanline,
    input  logic               rendering,
    input  logic               spr_h16,
    output logic [7:0]         oam_addr,
    input  logic [7:0]         oam_data,
    output logic               oam2_we,
    output logic [4:0]         oam2_addr,
    output logic [7:0]         oam2_wdata,
    output logic               spr_overflow,
    output logic               spr0_in_line,
    output logic [N_SLOTS-1:0] slot_valid
);
    import ppu_pkg::*;

    eval_state_t r_state;
    logic [5:0]  r_n;
    logic [1:0]  r_m;
    logic [3:0]  r_count;
    logic        r_spr0_next;

    eval_state_t w_state_nxt;
    logic [5:0]  w_n_nxt;
    logic [1:0]  w_m_nxt;
    logic [3:0]  w_count_nxt;
    logic        w_spr0_nxt;
    logic        w_ovf_set;
    logic        w_en;
    logic        w_even;
    logic        w_decide;
    logic        w_hit;
    logic        w_n_last;
    logic        w_latch;

    assign w_en     = rendering && (scanline <= LAST_VISIBLE);
    assign w_even   = ~cycle[0];
    assign w_decide = w_en && w_even && (cycle >= EVAL_FIRST) && (cycle <= EVAL_LAST);
    assign w_hit    = spr_in_range(scanline, oam_data, spr_h16);
    assign w_n_last = (r_n == 6'(N_SPRITES - 1));
    assign w_latch  = w_en && (cycle == EVAL_LAST) &&
                      (r_state inside {EVAL_Y, COPY, OVF_SCAN, DONE});
    assign oam_addr = {r_n, r_m};

    // State register, scan counters, sticky overflow and end-of-evaluation latches.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_n          <= '0;
            r_m          <= '0;
            r_count      <= '0;
            r_spr0_next  <= 1'b0;
            spr_overflow <= 1'b0;
            spr0_in_line <= 1'b0;
            slot_valid   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_n         <= w_n_nxt;
            r_m         <= w_m_nxt;
            r_count     <= w_count_nxt;
            r_spr0_next <= w_spr0_nxt;
            if (scanline == PRERENDER_LINE && cycle == CLEAR_FIRST) begin
                spr_overflow <= 1'b0;
            end else if (w_ovf_set) begin
                spr_overflow <= 1'b1;
            end
            // Latch the post-update count so a copy completing on the last dot is included.
            if (w_latch) begin
                slot_valid   <= N_SLOTS'((16'd1 << w_count_nxt) - 16'd1);
                spr0_in_line <= w_spr0_nxt;
            end
        end
    end

    // Next-state, counter updates and oam2 write port driven from the current dot.
    always_comb begin
        w_state_nxt = r_state;
        w_n_nxt     = r_n;
        w_m_nxt     = r_m;
        w_count_nxt = r_count;
        w_spr0_nxt  = r_spr0_next;
        w_ovf_set   = 1'b0;
        oam2_we     = 1'b0;
        oam2_addr   = '0;
        oam2_wdata  = '0;

        case (r_state)
            IDLE: begin
                if (cycle == CLEAR_FIRST) w_state_nxt = CLEAR;
            end
            CLEAR: begin
                if (w_even) begin
                    oam2_we    = 1'b1;
                    oam2_addr  = cycle[5:1] - 5'd1;
                    oam2_wdata = 8'hFF;
                end
                if (cycle == EVAL_FIRST - 9'd1) w_state_nxt = EVAL_Y;
            end
            EVAL_Y: begin
                if (w_decide) begin
                    if (w_hit) begin
                        oam2_we     = 1'b1;
                        oam2_addr   = {r_count[2:0], 2'b00};
                        oam2_wdata  = oam_data;
                        w_m_nxt     = 2'd1;
                        w_state_nxt = COPY;
                        if (r_n == '0) w_spr0_nxt = 1'b1;
                    end else begin
                        w_n_nxt = r_n + 6'd1;
                        if (w_n_last) w_state_nxt = DONE;
                    end
                end
            end
            COPY: begin
                if (w_decide) begin
                    oam2_we    = 1'b1;
                    oam2_addr  = {r_count[2:0], r_m};
                    oam2_wdata = oam_data;
                    if (r_m == 2'd3) begin
                        w_m_nxt     = '0;
                        w_count_nxt = r_count + 4'd1;
                        w_n_nxt     = r_n + 6'd1;
                        if (w_n_last)              w_state_nxt = DONE;
                        else if (r_count == 4'd7)  w_state_nxt = OVF_SCAN;
                        else                       w_state_nxt = EVAL_Y;
                    end else begin
                        w_m_nxt = r_m + 2'd1;
                    end
                end
            end
            OVF_SCAN: begin
                // m advances together with n and never carries into it.
                if (w_decide) begin
                    if (w_hit) begin
                        w_ovf_set   = 1'b1;
                        w_state_nxt = DONE;
                    end else begin
                        w_n_nxt = r_n + 6'd1;
                        w_m_nxt = r_m + 2'd1;
                        if (w_n_last) w_state_nxt = DONE;
                    end
                end
            end
            default: ;
        endcase

        if ((r_state inside {EVAL_Y, COPY, OVF_SCAN}) && cycle == EVAL_LAST) begin
            w_state_nxt = DONE;
        end
        if (cycle == '0) begin
            w_state_nxt = IDLE;
            w_n_nxt     = '0;
            w_m_nxt     = '0;
            w_count_nxt = '0;
            w_spr0_nxt  = 1'b0;
        end
        if (!w_en) w_state_nxt = IDLE;
        if (!w_en || !rst) begin
            oam2_we    = 1'b0;
            oam2_addr  = '0;
            oam2_wdata = '0;
        end
    end

endmodule

// File: tb/tb_sprite_eval.sv
// Self-checking bench for sprite_eval: directed lines plus randomized OAM
// contents compared against a line-level behavioural model of evaluation.
module tb_sprite_eval;

    logic       clk = 1'b0;
    logic       rst;
    logic [8:0] cycle;
    logic [8:0] scanline;
    logic       rendering;
    logic       spr_h16;
    logic [7:0] oam_addr;
    logic [7:0] oam_data;
    logic       oam2_we;
    logic [4:0] oam2_addr;
    logic [7:0] oam2_wdata;
    logic       spr_overflow;
    logic       spr0_in_line;
    logic [7:0] slot_valid;

    logic [7:0] oam_mem [256];

    int n_checks = 0;
    int n_errors = 0;

    logic [21:0] exp_wr [$];
    logic [21:0] got_wr [$];
    logic [7:0]  exp_sv  = '0;
    logic        exp_s0  = 1'b0;
    logic        exp_ovf = 1'b0;

    always #5 clk = ~clk;

    // Primary OAM with one-clock read latency.
    always @(posedge clk) oam_data <= oam_mem[oam_addr];

    sprite_eval #(.N_SLOTS(8), .N_SPRITES(64)) dut (
        .clk          (clk),
        .rst          (rst),
        .cycle        (cycle),
        .scanline     (scanline),
        .rendering    (rendering),
        .spr_h16      (spr_h16),
        .oam_addr     (oam_addr),
        .oam_data     (oam_data),
        .oam2_we      (oam2_we),
        .oam2_addr    (oam2_addr),
        .oam2_wdata   (oam2_wdata),
        .spr_overflow (spr_overflow),
        .spr0_in_line (spr0_in_line),
        .slot_valid   (slot_valid)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic covers(input int sl, input int y, input logic h16);
        return (sl >= y) && ((sl - y) < (h16 ? 16 : 8));
    endfunction

    // Walks the line as a sequence of two-dot OAM reads and lists every oam2 write.
    task automatic model_line(input int sl, input logic h16, input int drop);
        int t, n, m, cnt;
        logic s0, done;
        exp_wr.delete();
        for (int c = 2; c <= 64; c += 2)
            if (c < drop) exp_wr.push_back({9'(c), 5'(c / 2 - 1), 8'hFF});
        t = 66; n = 0; m = 0; cnt = 0; s0 = 1'b0; done = 1'b0;
        while (!done && t <= 256) begin
            if (cnt < 8) begin
                if (covers(sl, oam_mem[n * 4], h16)) begin
                    if (n == 0) s0 = 1'b1;
                    for (int k = 0; k < 4 && t <= 256; k++) begin
                        if (t < drop) exp_wr.push_back({9'(t), 5'(cnt * 4 + k), oam_mem[n * 4 + k]});
                        t += 2;
                        if (k == 3) cnt++;
                    end
                end else begin
                    t += 2;
                end
                n++;
                if (n == 64) done = 1'b1;
            end else begin
                if (covers(sl, oam_mem[n * 4 + m], h16)) begin
                    if (t < drop) exp_ovf = 1'b1;
                    done = 1'b1;
                end else begin
                    n++;
                    m = (m + 1) % 4;
                    t += 2;
                    if (n == 64) done = 1'b1;
                end
            end
        end
        if (drop > 256) begin
            exp_sv = 8'((1 << cnt) - 1);
            exp_s0 = s0;
        end
    endtask

    task automatic run_line(input int sl, input logic h16, input logic render, input int drop, input string name);
        if (render && sl <= 239) model_line(sl, h16, drop);
        else exp_wr.delete();
        if (sl == 261) exp_ovf = 1'b0;
        got_wr.delete();
        for (int c = 0; c <= 340; c++) begin
            @(posedge clk);
            #1;
            cycle     = 9'(c);
            scanline  = 9'(sl);
            spr_h16   = h16;
            rendering = render && (c < drop);
            @(negedge clk);
            if (oam2_we) got_wr.push_back({cycle, oam2_addr, oam2_wdata});
        end
        check({name, "_nwr"}, got_wr.size(), exp_wr.size());
        for (int i = 0; i < got_wr.size() && i < exp_wr.size(); i++)
            check($sformatf("%s_wr%0d", name, i), 32'(got_wr[i]), 32'(exp_wr[i]));
        check({name, "_slot_valid"}, 32'(slot_valid), 32'(exp_sv));
        check({name, "_spr0"}, 32'(spr0_in_line), 32'(exp_s0));
        check({name, "_ovf"}, 32'(spr_overflow), 32'(exp_ovf));
    endtask

    task automatic fill_oam(input logic [7:0] v);
        for (int i = 0; i < 256; i++) oam_mem[i] = v;
    endtask

    initial begin
        int sl, drop;
        logic h16, rnd;

        fill_oam(8'hF0);
        rst = 1'b0; rendering = 1'b1; spr_h16 = 1'b0;
        scanline = 9'd10; cycle = 9'd2;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            cycle = 9'(2 + 2 * i);
            @(negedge clk);
            check($sformatf("reset_outs%0d", i),
                  {oam_addr, oam2_we, oam2_addr, oam2_wdata, spr_overflow, spr0_in_line, slot_valid},
                  32'd0);
        end
        rst = 1'b1;

        run_line(10, 1'b0, 1'b1, 999, "clear");

        oam_mem[0] = 8'd5; oam_mem[1] = 8'h21; oam_mem[2] = 8'h03; oam_mem[3] = 8'h40;
        run_line(10, 1'b0, 1'b1, 999, "single");

        fill_oam(8'hF0);
        oam_mem[12] = 8'd2;
        run_line(10, 1'b0, 1'b1, 999, "h8");
        run_line(10, 1'b1, 1'b1, 999, "h16");

        fill_oam(8'hF0);
        for (int s = 0; s < 8; s++) oam_mem[s * 4] = 8'd10;
        oam_mem[37] = 8'h08;
        run_line(10, 1'b0, 1'b1, 100, "abort");
        run_line(10, 1'b0, 1'b1, 999, "ovf");
        run_line(261, 1'b0, 1'b1, 999, "prerender");
        run_line(11, 1'b0, 1'b1, 999, "after");

        for (int r = 0; r < 24; r++) begin
            sl  = $urandom_range(0, 239);
            h16 = 1'($urandom_range(0, 1));
            rnd = ($urandom_range(0, 7) != 0);
            drop = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 340) : 999;
            if ($urandom_range(0, 5) == 0) sl = 261;
            for (int s = 0; s < 64; s++) begin
                for (int b = 0; b < 4; b++) oam_mem[s * 4 + b] = 8'($urandom);
                if ($urandom_range(0, 3) == 0) oam_mem[s * 4] = 8'(sl - $urandom_range(0, 17));
            end
            run_line(sl, h16, rnd, drop, $sformatf("rand%0d", r));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/sprite_eval.md
Name: sprite_eval

Overview:
Per-scanline sprite evaluation for the PPU. It is the producer side of secondary OAM (oam2), which the per-slot sprite units consume. On each visible line it clears oam2, scans the 64 primary-OAM entries for sprites that fall on the next line, and copies up to 8 of them into oam2. It also raises the sprite-overflow flag, including the NES m-increment hardware bug, and reports slot validity and sprite-0 presence to the fetch and sprite units.

Parameters:
N_SLOTS, 8, oam2 sprite slots; must be 8 for NES compatibility.
N_SPRITES, 64, primary OAM entries.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-low (reset when rst==0 at posedge clk)
cycle  in  9  PPU dot within line, 0..340
scanline  in  9  0..239 visible, 261 pre-render
rendering  in  1  background or sprite rendering enabled
spr_h16  in  1  1 = 8x16 sprites, 0 = 8x8
oam_addr  out  8  primary OAM read address; data returns the following clock
oam_data  in  8  primary OAM read data
oam2_we  out  1  oam2 write strobe
oam2_addr  out  5  oam2 write address {slot[2:0], byte[1:0]}
oam2_wdata  out  8  oam2 write data
spr_overflow  out  1  PPUSTATUS bit 5
spr0_in_line  out  1  oam2 slot 0 holds OAM sprite 0; feeds sprite-0-hit logic
slot_valid  out  8  bit i = oam2 slot i holds a real sprite; drives sprite inscan

Behaviour:
- Reset: all outputs 0, state IDLE, n=m=count=0.
- Evaluation runs only when rendering=1 and scanline<=239. Otherwise the block stays in IDLE and oam2_we=0.
- State machine: IDLE -> CLEAR (cycle 1) -> EVAL_Y (cycle 65) -> COPY / OVF_SCAN -> DONE -> IDLE (cycle 0).
- CLEAR, cycles 1..64:
  - On even cycle c: oam2_we=1, oam2_addr=(c>>1)-1, oam2_wdata=8'hFF.
  - Result: 32 writes covering addresses 0..31.
- Byte access pattern, cycles 65..256:
  - Odd cycle: oam_addr={n[5:0], m[1:0]}.
  - Following even cycle: oam_data is valid; the decision is made and any write happens in that same cycle.
- Range test: d = scanline - {1'b0, oam_data}, computed 9-bit unsigned. The sprite is in range iff d < (spr_h16 ? 16 : 8).
- EVAL_Y (m=0, count<8):
  - In range: write Y to oam2[{count,2'b0}], go to COPY with m=1. If n==0, set spr0_next.
  - Out of range: no write, n++, stay in EVAL_Y.
- COPY: bytes m=1..3 are each written to oam2[{count,m}] using the 2-cycle pattern. After m=3: count++, n++, m=0. Next state is EVAL_Y if count<8, else OVF_SCAN.
- OVF_SCAN (count==8, hardware bug reproduced):
  - Each read uses {n,m}.
  - In range: spr_overflow<=1, go to DONE.
  - Out of range: n++ and m<=(m+1)&3, with no carry from m into n.
  - No oam2 writes occur in this state.
- n wrap: if n increments past 63 in any state, go to DONE. Likewise, if cycle 256 is reached while not in DONE, go to DONE.
- Latching at cycle 256 (end of evaluation):
  - slot_valid <= (1<<count)-1.
  - spr0_in_line <= spr0_next.
  - These hold until the next cycle 256 of an evaluated line.
- Line start: at cycle 0 of each line, n, m, count and spr0_next are cleared.
- spr_overflow clear: cleared at scanline 261, cycle 1, regardless of rendering. A set in the same cycle loses to the clear.
- Rendering deassert mid-line: the next clock enters IDLE and oam2_we=0 immediately. spr_overflow, slot_valid and spr0_in_line hold their values.
- Reset mid-operation: reset wins over every event and restores all reset values.
- Timing bounds:
  - Worst-case scan (no hits) finishes at cycle 192.
  - 8 hits starting at sprite 0 finish COPY by cycle 128.

Decomposition:
- ppu_pkg holds:
  - enum eval_state_t {IDLE, CLEAR, EVAL_Y, COPY, OVF_SCAN, DONE}.
  - Constants CLEAR_FIRST=1, EVAL_FIRST=65, EVAL_LAST=256, PRERENDER_LINE=261.
  - Function spr_in_range(scanline, y, h16).
- No sub-module; the block is a single FSM with counters.

Test Plan:
- Reset: hold rst=0 for 2 clocks with rendering=1 -> all outputs 0, oam2_we=0 throughout.
- Clear: rendering=1, scanline=10 -> exactly 32 writes on cycles 2,4..64, addresses 0..31, data 8'hFF.
- Single hit: OAM[0..3]={5,8'h21,8'h03,8'h40}, all other Y=8'hF0, scanline=10, 8x8 -> writes oam2[0..3]=those bytes on cycles 66,68,70,72. After cycle 256: slot_valid=8'h01, spr0_in_line=1.
- Height mode: sprite 3 Y=2, scanline=10 -> no copy with spr_h16=0, slot_valid=0. With spr_h16=1: copied to slot 0, spr0_in_line=0.
- Overflow bug: sprites 0..7 Y=10, sprite 8 Y=8'hF0, OAM[37]=8'h08, scanline=10 -> 8 slots filled, slot_valid=8'hFF, spr_overflow=1 (false positive via m=1 read). Then scanline 261 cycle 1 -> spr_overflow=0.
- Abort: drop rendering at cycle 100 mid-COPY -> no oam2_we after cycle 100. Previous slot_valid holds; the FSM restarts cleanly on the next line.
